// File: rtl/send_sched.sv
// send_sched: grants the shared inter-PU copy link to one SEND requester and streams
// size words src->dest at one word/cycle. Define SEND_SCHED_RR_EN for round-robin arbitration.
module send_sched #(
  parameter int PU_NUM = 4,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int SW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PU_NUM-1:0]    req,
  input  logic [PU_NUM*AW-1:0] addr,
  input  logic [PU_NUM*SW-1:0] size,
  input  logic [PU_NUM*4-1:0]  port,
  output logic [PU_NUM-1:0]    busy,
  output logic [PU_NUM-1:0]    ack,
  output logic                 err,
  output logic [PU_NUM-1:0]    rd_sel,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        rd_data,
  output logic [PU_NUM-1:0]    wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data
);
  localparam int PW = $clog2(PU_NUM);
  localparam logic [PU_NUM-1:0] ONE = PU_NUM'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     g_q, g_d, dest_q, dest_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [PU_NUM-1:0] busy_q, busy_d, ack_q, ack_d, rd_sel_q, rd_sel_d, wr_en_q, wr_en_d;
  logic              err_q, err_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  logic              gnt_vld;
  logic [PW-1:0]     gnt;

`ifdef SEND_SCHED_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Scan downward so the nearest requester after ptr_q is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = PU_NUM; k >= 1; k--) begin
      if (req[ptr_q + PW'(k)]) begin
        gnt_vld = 1'b1;
        gnt     = ptr_q + PW'(k);
      end
    end
    ptr_d = (state_q == IDLE && gnt_vld) ? gnt : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PW'(PU_NUM - 1);
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = PU_NUM - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(k);
      end
    end
  end
`endif

  logic [AW-1:0] a_g;
  logic [SW-1:0] s_g;
  logic [3:0]    p_g;
  logic          bad_port;

  assign a_g      = addr[gnt*AW +: AW];
  assign s_g      = size[gnt*SW +: SW];
  assign p_g      = port[gnt*4 +: 4];
  assign bad_port = 32'(p_g) >= PU_NUM;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ack_d     = '0;
    err_d     = 1'b0;
    rd_sel_d  = rd_sel_q;
    rd_addr_d = rd_addr_q;
    // Every read issued last cycle becomes a write this cycle, in STREAM and DRAIN alike.
    wr_en_d   = (rd_sel_q != '0) ? (ONE << dest_q) : '0;
    wr_addr_d = rd_addr_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        g_d    = gnt;
        dest_d = PW'(p_g);
        busy_d = ONE << gnt;
        if (bad_port || s_g == '0) begin
          state_d = DONE;
          ack_d   = ONE << gnt;
          err_d   = bad_port;
        end else begin
          state_d   = STREAM;
          cnt_d     = s_g;
          rd_sel_d  = ONE << gnt;
          rd_addr_d = a_g;
        end
      end
      STREAM: begin
        if (cnt_q == SW'(1)) begin
          state_d  = DRAIN;
          rd_sel_d = '0;
        end else begin
          cnt_d     = cnt_q - SW'(1);
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        ack_d   = ONE << g_q;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rd_sel_q  <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_sel_q  <= rd_sel_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rd_sel  = rd_sel_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  // Source memory returns data the cycle after the read, which is the write cycle.
  assign wr_data = (wr_en_q != '0) ? rd_data : '0;

endmodule

// File: tb/tb_send_sched.sv
// Scoreboard bench for send_sched: stimulus pushes expected writes/acks, a negedge monitor pops and compares.
module tb_send_sched;
  localparam int PU_NUM = 4, AW = 8, DW = 16, SW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [PU_NUM-1:0]    req;
  logic [PU_NUM*AW-1:0] addr;
  logic [PU_NUM*SW-1:0] size;
  logic [PU_NUM*4-1:0]  port;
  logic [PU_NUM-1:0]    busy, ack, rd_sel, wr_en;
  logic                 err;
  logic [AW-1:0]        rd_addr, wr_addr;
  logic [DW-1:0]        rd_data, wr_data;

  send_sched #(.PU_NUM(PU_NUM), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .size(size), .port(port),
    .busy(busy), .ack(ack), .err(err), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ack;
    bit         err;
    logic [3:0] oh;
    logic [7:0] a;
    logic [15:0] d;
    int         c;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mism = 0;

  function automatic logic [15:0] pat(int p, logic [7:0] a);
    return {4'(p), 4'hA, a};
  endfunction

  // Source memories: read-only pattern, registered read.
  always @(posedge clk) begin
    rd_data <= '0;
    for (int i = 0; i < PU_NUM; i++) if (rd_sel[i]) rd_data <= pat(i, rd_addr);
  end

  exp_t mon_e;
  bit   mon_ok;
  always @(negedge clk) begin
    if ($countones(rd_sel) > 1) begin
      compared++; mism++;
      $display("FAIL rd_sel_onehot cyc=%0d got=%b", cyc, rd_sel);
    end
    if (wr_en != '0 || ack != '0 || err) begin
      compared++;
      if (q.size() == 0) begin
        mism++;
        $display("FAIL unexpected_event cyc=%0d wr_en=%b ack=%b err=%b wr_addr=%h", cyc, wr_en, ack, err, wr_addr);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.is_ack)
          mon_ok = (wr_en == '0) && (ack == mon_e.oh) && (err == mon_e.err) && (cyc == mon_e.c);
        else
          mon_ok = (ack == '0) && !err && (wr_en == mon_e.oh) && (wr_addr == mon_e.a) &&
                   (wr_data == mon_e.d) && (cyc == mon_e.c);
        if (!mon_ok)
          $display("FAIL %s got cyc=%0d wr_en=%b ack=%b err=%b addr=%h data=%h, need cyc=%0d oh=%b err=%b addr=%h data=%h",
                   mon_e.is_ack ? "ack" : "write", cyc, wr_en, ack, err, wr_addr, wr_data,
                   mon_e.c, mon_e.oh, mon_e.err, mon_e.a, mon_e.d);
        if (!mon_ok) mism++;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s got=%0h need=%0h", nm, got, exp);
    end
  endtask

  task automatic push_w(int d, logic [7:0] a, logic [15:0] dat, int c);
    exp_t e;
    e.is_ack = 0; e.err = 0; e.oh = 4'(1 << d); e.a = a; e.d = dat; e.c = c;
    q.push_back(e);
  endtask

  task automatic push_ack(int p, bit er, int c);
    exp_t e;
    e.is_ack = 1; e.err = er; e.oh = 4'(1 << p); e.a = '0; e.d = '0; e.c = c;
    q.push_back(e);
  endtask

  // Expected response of one grant sampled in cycle t.
  task automatic push_copy(int p, int d, logic [7:0] a, int n, int t);
    if (d >= PU_NUM || n == 0) push_ack(p, d >= PU_NUM, t + 1);
    else begin
      for (int i = 0; i < n; i++) push_w(d, 8'(a + 8'(i)), pat(p, 8'(a + 8'(i))), t + 2 + i);
      push_ack(p, 0, t + n + 2);
    end
  endtask

  task automatic single(int p, logic [7:0] a, int n, int d, int drop_at);
    bit got;
    @(negedge clk);
    addr[p*8 +: 8] = a; size[p*8 +: 8] = 8'(n); port[p*4 +: 4] = 4'(d); req[p] = 1'b1;
    push_copy(p, d, a, n, cyc);
    @(negedge clk);
    chk($sformatf("busy_pu%0d", p), 32'(busy), 32'(1 << p));
    got = 0;
    for (int k = 0; k < 600 && !got; k++) begin
      if (ack[p]) got = 1;
      else begin
        if (k == drop_at) req[p] = 1'b0;
        @(negedge clk);
      end
    end
    if (!got) begin
      compared++; mism++;
      $display("FAIL ack_timeout pu=%0d got=0 need=1", p);
    end
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c, acks, nexp, idx;
    int order[$];
    rst = 1'b1; req = '0; addr = '0; size = '0; port = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_sel", 32'(rd_sel), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addrs", {16'(rd_addr), 16'(wr_addr)}, 0);
    rst = 1'b0;
    @(negedge clk);

    single(1, 8'h10, 4, 3, -1);   // basic copy, ack at T+6
    single(0, 8'hFE, 4, 2, -1);   // address wrap
    single(2, 8'h20, 0, 1, -1);   // zero size
    single(3, 8'h30, 5, 7, -1);   // invalid destination
    single(2, 8'h55, 3, 2, -1);   // self copy
    single(3, 8'h60, 6, 1, 1);    // req dropped in STREAM

    // Contention: all four request; PU0 holds req until the fifth ack.
`ifdef SEND_SCHED_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0, 1, 2, 3};
`endif
    nexp = order.size();
    @(negedge clk);
    for (int p = 0; p < PU_NUM; p++) begin
      addr[p*8 +: 8] = 8'(8'h40 + 16 * p); size[p*8 +: 8] = 8'd2; port[p*4 +: 4] = 4'((p + 1) % PU_NUM);
    end
    req = 4'hF;
    c = cyc;
    for (int k = 0; k < nexp; k++)
      push_copy(order[k], (order[k] + 1) % PU_NUM, 8'(8'h40 + 16 * order[k]), 2, c + 5 * k);
    acks = 0;
    for (int k = 0; k < 200 && acks < nexp; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        acks++;
        idx = 0;
        for (int i = 0; i < PU_NUM; i++) if (ack[i]) idx = i;
        if (idx != 0) req[idx] = 1'b0;
        if (acks == 5) req[0] = 1'b0;
      end
    end
    chk("contention_ack_count", acks, nexp);
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during the fifth read of a 10-word copy.
    @(negedge clk);
    addr[2*8 +: 8] = 8'h80; size[2*8 +: 8] = 8'd10; port[2*4 +: 4] = 4'd0; req[2] = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) push_w(0, 8'(8'h80 + i), pat(2, 8'(8'h80 + i)), c + 2 + i);
    repeat (5) @(negedge clk);
    chk("fifth_read_addr", {28'(rd_sel), 8'(rd_addr)} & 32'hFF, 32'h84);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_outs", {4'(rd_sel), 4'(wr_en), 4'(ack), 3'b0, err}, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    single(1, 8'h05, 2, 0, -1);   // recovery after reset

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running need=finished");
    $fatal(1);
  end
endmodule

// File: doc/send_sched.md
# send_sched

Shared-link scheduler for the SEND instruction (port `addr(a), size(b), port(im)`) issued by the four PUs. It arbitrates simultaneous SEND requests and grants the single inter-PU copy link to one PU at a time. For the granted PU it streams `size` words from its data memory to the same addresses in the destination PU's data memory at one word per cycle. It acknowledges the requester when the copy is done. The requesting PU stalls until that acknowledge.

## Interface
Parameters:
- PU_NUM, 4 — number of PUs (requesters and destinations); power of two, ≥2
- AW, 8 — data-memory address width
- DW, 16 — data word width
- SW, 8 — size field width

Ports:
- clk  in  1  — single clock
- rst  in  1  — synchronous, active-high reset
- req  in  PU_NUM  — per-PU SEND request; level, held by the PU until its ack
- addr  in  PU_NUM*AW  — flattened start address per PU (PU i at [i*AW +: AW])
- size  in  PU_NUM*SW  — flattened word count per PU
- port  in  PU_NUM*4  — flattened destination PU index per PU
- busy  out  PU_NUM  — PU i is granted and its transfer is in progress
- ack  out  PU_NUM  — one-cycle completion pulse to the granted PU
- err  out  1  — one-cycle pulse, same cycle as ack, when the destination is invalid
- rd_sel  out  PU_NUM  — one-hot source data-memory read select
- rd_addr  out  AW  — source read address
- rd_data  in  DW  — source read data; valid the cycle after rd_sel/rd_addr
- wr_en  out  PU_NUM  — one-hot destination data-memory write enable
- wr_addr  out  AW  — destination write address
- wr_data  out  DW  — destination write data

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - If any `req` bit is set, pick one winner `g` using the arbitration below.
  - Latch `addr[g]`, `size[g]` and `port[g]`, and set `busy[g]`.
  - If `port[g] ≥ PU_NUM`, or `size[g]==0`, go to DONE. Otherwise go to STREAM.
- Arbitration:
  - Requests are sampled only in IDLE.
  - `req` bits that change while not in IDLE have no effect until the next IDLE cycle.
- STREAM:
  - Issue one read per cycle: `rd_sel=onehot(g)`, `rd_addr=a+i` for i=0..size-1.
  - The last read moves the block to DRAIN.
- Write pipeline:
  - One cycle after each read, assert `wr_en=onehot(dest)` with `wr_addr=` the address of that read and `wr_data=rd_data`.
  - This applies in both STREAM and DRAIN.
- DRAIN: performs the final write, then moves to DONE.
- DONE:
  - Pulse `ack[g]`; pulse `err` if the destination is invalid.
  - Clear `busy` and return to IDLE.
- Address arithmetic: modulo 2^AW; a+i wraps past the top of memory to 0.
- `size` is unsigned; the maximum is 2^SW−1 words.
- `dest==g` is legal: the block performs a self-copy and the memory contents are unchanged.
- A request deasserted mid-transfer is ignored. The transfer completes and ack still pulses.
- After ack, a PU that still holds `req` high is treated as a new request.

## Timing
- Reset values: state=IDLE, `busy`=0, `ack`=0, `err`=0, `rd_sel`=0, `wr_en`=0, all addresses and data=0, round-robin pointer=PU_NUM−1 (so PU0 has first priority).
- With `req` sampled in IDLE at cycle T:
  - `busy` rises at T+1.
  - Reads occur at T+1 .. T+size.
  - Writes occur at T+2 .. T+size+1.
  - `ack` pulses at T+size+2.
  - IDLE resumes at T+size+3.
- `size==0` or invalid port: `ack` (and `err` for an invalid port) at T+1, with no reads or writes.
- At most one `rd_sel` bit, one `wr_en` bit and one `ack` bit are high in any cycle.
- Minimum gap between back-to-back grants is one IDLE cycle.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values. No further writes and no ack are issued; writes already made stay in memory.

## Configuration
- Macro: SEND_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at the PU after the last granted one.
  - The pointer updates to `g` on every grant.
- Undefined: fixed priority, lowest-index requester wins; the pointer logic is removed.

## Test plan
- Single copy, PU1→PU3:
  - Stimulus: `addr`=0x10, `size`=4, `port`=3.
  - Required: writes to PU3 at 0x10..0x13 with PU1's data; `ack[1]` exactly 6 cycles after the request is sampled.
- Wrap:
  - Stimulus: PU0, `addr`=0xFE, `size`=4, `port`=2.
  - Required: writes to 0xFE, 0xFF, 0x00, 0x01.
- Zero and invalid:
  - `size`=0 → `ack` at T+1 with no `wr_en`.
  - `port`=7 → `ack` and `err` at T+1 with no `wr_en`.
- Contention:
  - Stimulus: all four `req` held, each `size`=2.
  - With SEND_SCHED_RR_EN: grant order 0,1,2,3, then 0 again if requests are re-raised.
  - Without it: PU0 is regranted each time it re-requests.
- Reset mid-transfer:
  - Stimulus: `size`=10, `rst` asserted during the 5th read.
  - Required: no `wr_en` and no `ack` after reset; `busy`=0.
- Mid-transfer deassert:
  - Stimulus: `req` dropped in STREAM.
  - Required: all `size` words are written and `ack` still pulses.
